// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative AES MixColumns stage. An accepted 128-bit state is copied into a
// work register. A single column mixer then rewrites one column per clock,
// columns 0 to 3. The finished state is held on data_out until downstream
// takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   upstream presents a state on data_in
//   in_ready   state on data_in is accepted this cycle
//   data_in    AES state, column c = bits [127-32c -: 32], row 0 in top byte
//   inv        InvMixColumns select, latched on acceptance
//   out_valid  data_out holds a finished state
//   out_ready  downstream consumes data_out this cycle
//   data_out   mixed state, same layout as data_in
//
// Configuration
//   MIX_COLUMNS_INV_EN  When defined, a latched inv=1 selects InvMixColumns.
//                       When undefined, inv is ignored and only the forward
//                       mixer is built.
// -----------------------------------------------------------------------------
module mix_columns_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_reg;
  logic [1:0]   col_cnt_reg;
  logic [127:0] work_reg;
  logic         out_valid_reg;

  logic [31:0]  col_words [4];
  logic [31:0]  col_sel;
  logic [31:0]  col_mixed;
  logic         accept;

  // Multiply by x in GF(2^8) with reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
            xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
            xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic inv_reg;

  // Multiply by a constant nibble k. k is always a literal here, so the
  // unused partial products fold away.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] m2, m4, m8;
    m2 = xtime(x);
    m4 = xtime(m2);
    m8 = xtime(m4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? m2 : 8'h00) ^
           (k[2] ? m4 : 8'h00) ^ (k[3] ? m8 : 8'h00);
  endfunction

  // b_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3)
  function automatic logic [7:0] inv_byte(input logic [7:0] p, input logic [7:0] q,
                                          input logic [7:0] r, input logic [7:0] s);
    return gmul(p, 4'he) ^ gmul(q, 4'hb) ^ gmul(r, 4'hd) ^ gmul(s, 4'h9);
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {inv_byte(a0, a1, a2, a3), inv_byte(a1, a2, a3, a0),
            inv_byte(a2, a3, a0, a1), inv_byte(a3, a0, a1, a2)};
  endfunction

  assign col_mixed = inv_reg ? mix_inv(col_sel) : mix_fwd(col_sel);
`else
  // inv is part of the interface but has no effect in this build.
  logic unused_inv;
  assign unused_inv = inv;
  assign col_mixed  = mix_fwd(col_sel);
`endif

  // Split the work register into columns so one mixer can be muxed across them.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col_words[gi] = work_reg[127-32*gi -: 32];
  end

  assign col_sel   = col_words[col_cnt_reg];

  // In DONE, a new state can be taken on the same edge the old one leaves.
  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign data_out  = work_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_cnt_reg   <= 2'd0;
      work_reg      <= '0;
      out_valid_reg <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg       <= 1'b0;
`endif
    end else if (accept) begin
      // Acceptance happens only in IDLE or in DONE. In DONE it also consumes
      // the finished state.
      work_reg      <= data_in;
      col_cnt_reg   <= 2'd0;
      state_reg     <= BUSY;
      out_valid_reg <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg       <= inv;
`endif
    end else begin
      case (state_reg)
        BUSY: begin
          for (int i = 0; i < 4; i++) begin
            if (col_cnt_reg == 2'(i)) begin
              work_reg[127-32*i -: 32] <= col_mixed;
            end
          end
          col_cnt_reg <= col_cnt_reg + 2'd1;  // wraps to 0 after column 3
          if (col_cnt_reg == 2'd3) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int assert_cnt;
  int fail_cnt;

  localparam logic [127:0] FWD_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  // forward mix of FWD_OUT, hand computed column by column
  localparam logic [127:0] FWD2_OUT = 128'hcd504506_9f494f1f_01010101_c6c6c6c6;
  localparam logic [127:0] BND_IN   = 128'h80808080_d4d4d4d5_00000000_ffffffff;
  localparam logic [127:0] BND_OUT  = 128'h80808080_d5d5d7d6_00000000_ffffffff;

  mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .inv       (inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present one state while IDLE, then return the number of edges after
  // acceptance until out_valid rises. Returns 0 if it never rises.
  task automatic send(input logic [127:0] d, input logic inv_bit, output int lat);
    lat = 0;
    data_in  = d;
    inv      = inv_bit;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) check_val("busy_in_ready", 128'(in_ready), 128'(0));
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("consume_out_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    int lat;
    logic [127:0] held;
    logic [127:0] b2b_in  [3];
    logic [127:0] b2b_exp [3];
    int acc_cyc [3];
    int n_acc, n_out, cyc, xfers;
    logic do_acc, do_out;
    logic saw_valid;

    assert_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    inv        = 1'b0;
    out_ready  = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 128'(out_valid), 128'(0));
    check_val("rst_data_out", data_out, 128'(0));
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Forward vector and latency
    send(FWD_IN, 1'b0, lat);
    check_val("fwd_latency", 128'(lat), 128'(4));
    check_val("fwd_data", data_out, FWD_OUT);
    consume();

    // Inverse vector. Without the inverse build it mixes forward.
    send(FWD_OUT, 1'b1, lat);
    check_val("inv_latency", 128'(lat), 128'(4));
`ifdef MIX_COLUMNS_INV_EN
    check_val("inv_data", data_out, FWD_IN);
`else
    check_val("inv_data", data_out, FWD2_OUT);
`endif
    consume();

    // Boundary bytes (0x80 and xtime reduction)
    send(BND_IN, 1'b0, lat);
    check_val("bnd_data", data_out, BND_OUT);

    // Backpressure: hold 10 cycles in DONE
    held = data_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("bp_out_valid", 128'(out_valid), 128'(1));
      check_val("bp_data_hold", data_out, held);
      check_val("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_one_transfer", 128'(xfers), 128'(1));

    // Back-to-back: 3 states with in_valid and out_ready held high
    b2b_in[0]  = FWD_IN;  b2b_exp[0] = FWD_OUT;
    b2b_in[1]  = BND_IN;  b2b_exp[1] = BND_OUT;
    b2b_in[2]  = FWD_OUT; b2b_exp[2] = FWD2_OUT;
    n_acc = 0; n_out = 0; cyc = 0;
    data_in   = b2b_in[0];
    inv       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (n_out < 3 && cyc < 60) begin
      @(negedge clk);
      do_acc = in_valid && in_ready;
      do_out = out_valid && out_ready;
      if (do_out) begin
        check_val("b2b_out", data_out, b2b_exp[n_out]);
        n_out++;
      end
      @(posedge clk); #1;
      cyc++;
      if (do_acc) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 3) in_valid = 1'b0;
        else data_in = b2b_in[n_acc];
      end
    end
    check_val("b2b_n_out", 128'(n_out), 128'(3));
    check_val("b2b_n_acc", 128'(n_acc), 128'(3));
    if (n_acc == 3) begin
      check_val("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(5));
      check_val("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(5));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset mid-BUSY after two column edges
    data_in  = BND_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_out_valid", 128'(out_valid), 128'(0));
    check_val("midrst_data_out", data_out, 128'(0));
    check_val("midrst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_val("midrst_no_emit", 128'(saw_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 in_valid  input  1  The upstream shift-rows stage is presenting a state on data_in.
REQ-005 in_ready  output  1  The block accepts data_in this cycle.
REQ-006 data_in  input  128  AES state, column-major: column c = bits [127-32c -: 32], row 0 in the top byte of each column.
REQ-007 inv  input  1  Inverse-MixColumns select, sampled on acceptance (see Configuration).
REQ-008 out_valid  output  1  data_out holds a finished state.
REQ-009 out_ready  input  1  The downstream add-round-key stage consumes data_out this cycle.
REQ-010 data_out  output  128  Mixed state, same byte layout as data_in.

Function
REQ-011 Acceptance SHALL occur on a rising edge where in_valid && in_ready.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; on acceptance the FSM SHALL capture data_in into a work register, latch inv, clear col_cnt to 0 and go to BUSY.
REQ-014 In BUSY, in_ready SHALL be 0.
REQ-015 Each BUSY edge SHALL replace column col_cnt of the work register with its mixed value, then increment col_cnt.
REQ-016 On the edge that processes column 3, col_cnt SHALL wrap to 0 and the FSM SHALL go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly 4 edges after the acceptance edge (after edges E1..E4).
REQ-018 In DONE, out_valid SHALL be 1, and data_out and out_valid SHALL hold stable until out_ready is 1.
REQ-019 In DONE, in_ready SHALL equal out_ready (combinational).
REQ-020 In DONE with out_ready=1 and in_valid=1, the output SHALL be consumed and the new state accepted on the same edge, going to BUSY; throughput is one state per 5 cycles.
REQ-021 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE and out_valid SHALL be 0 on the next cycle.
REQ-022 Forward mix per column (a0..a3): b_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4, arithmetic in GF(2^8) with polynomial 0x11B.
REQ-023 xtime(x) SHALL be (x<<1)[7:0] ^ (x[7] ? 0x1B : 0x00).
REQ-024 One column mixer SHALL be instantiated and shared across the 4 cycles; four parallel mixers are not permitted.
REQ-025 data_out SHALL be driven directly from the work register, which holds partial values during BUSY.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set FSM=IDLE, col_cnt=0, work register=0 (so data_out=0), latched inv=0 and out_valid=0.
REQ-027 rst SHALL take priority over acceptance and over the BUSY/DONE transitions.
REQ-028 A state in flight when reset is asserted SHALL be discarded, with no out_valid pulse for it.
REQ-029 in_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-030 With macro MIX_COLUMNS_INV_EN defined, latched inv=1 SHALL select InvMixColumns: b_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3).
REQ-031 Without MIX_COLUMNS_INV_EN, the inv port SHALL exist but be ignored, forward mixing SHALL always be used, and no inverse logic SHALL be synthesized.

Verification
REQ-032 Forward vector: data_in=0xdb135345_f20a225c_01010101_c6c6c6c6, inv=0 -> data_out=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising 4 edges after acceptance.
REQ-033 Inverse vector (macro defined): data_in=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv=1 -> data_out=0xdb135345_f20a225c_01010101_c6c6c6c6; without the macro the same stimulus yields the forward result.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, data_out is unchanged and in_ready=0; release -> exactly one transfer.
REQ-035 Back-to-back: in_valid held 1 and out_ready=1 with 3 states -> acceptances 5 cycles apart, and outputs in order each match the golden mixed value.
REQ-036 Reset mid-BUSY: assert rst after 2 column edges -> next cycle out_valid=0, data_out=0, in_ready=1, and the aborted state is never emitted.
REQ-037 Boundary byte: column 0x80808080 -> 0x80808080; column 0xd4d4d4d5 -> 0xd5d5d7d6 (exercises the xtime reduction).
